// File: rtl/sync_fifo_wr_arb_pkg.sv
// Shared types and defaults for the sync FIFO write-port arbiter.
package sync_fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 8;

    // Beat counter only needs to reach MAX_BURST-1; keep at least one bit.
    function automatic int beat_cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_wr_arb_if.sv
// Producer-side handshake and FIFO enqueue bus seen by the write-port arbiter.
interface sync_fifo_wr_arb_if
    import sync_fifo_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    top_wr_en;
    logic [DATA_W-1:0]       top_wr_data;
    logic                    enq_fifo_full;
    logic                    overflow;

    modport master (
        input  req_valid, req_data, req_last, enq_fifo_full, overflow,
        output req_ready, top_wr_en, top_wr_data
    );

    modport slave (
        output req_valid, req_data, req_last, enq_fifo_full, overflow,
        input  req_ready, top_wr_en, top_wr_data
    );

endinterface

// File: rtl/sync_fifo_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module sync_fifo_rr_picker
    import sync_fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     found
);

    localparam int IDX_W = $clog2(N_REQ);

    int               pos;
    logic [IDX_W-1:0] idx;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        idx    = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            pos = int'(last_grant) + off;
            if (pos >= N_REQ) pos = pos - N_REQ;
            idx = IDX_W'(pos);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin, burst-locked arbiter sharing the sync FIFO enqueue port among N producers.
// Optional per-requester grant counters: define SYNC_FIFO_ARB_STATS_EN.
module sync_fifo_wr_arb
    import sync_fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
`ifdef SYNC_FIFO_ARB_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                     clk,
    input  logic                     hw_rst,
    input  logic                     sw_rst,
    sync_fifo_wr_arb_if.master       bus,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     arb_busy,
    output logic                     ovf_err
`ifdef SYNC_FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]   grant_cnt
`endif
);

    localparam int               IDX_W      = $clog2(N_REQ);
    localparam int               BC_W       = beat_cnt_width(MAX_BURST);
    localparam logic [BC_W-1:0]  BEAT_LAST  = BC_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(N_REQ - 1);

    arb_state_e        state;
    logic [IDX_W-1:0]  last_grant;
    logic [BC_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]  pick_id;
    logic              pick_found;
    logic              in_burst;
    logic              beat;
    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    sync_fifo_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .winner     (pick_id),
        .found      (pick_found)
    );

    // A soft reset kills the burst in the same cycle so nothing is written while it is asserted.
    always_comb begin
        in_burst        = (state == ARB_BURST) && !sw_rst;
        beat            = in_burst && bus.req_valid[grant_id] && !bus.enq_fifo_full;
        bus.req_ready   = '0;
        if (in_burst) bus.req_ready[grant_id] = ~bus.enq_fifo_full;
        bus.top_wr_en   = beat;
        bus.top_wr_data = beat ? data_arr[grant_id] : '0;
        arb_busy        = in_burst;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            last_grant <= LAST_INIT;
            beat_cnt   <= '0;
            ovf_err    <= 1'b0;
        end else if (sw_rst) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            last_grant <= LAST_INIT;
            beat_cnt   <= '0;
            ovf_err    <= 1'b0;
        end else begin
            if (bus.overflow || (beat && bus.enq_fifo_full)) ovf_err <= 1'b1;
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_id   <= pick_id;
                        last_grant <= pick_id;
                        beat_cnt   <= '0;
                        state      <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    // A beat held off by full never ends the burst, even if it carries last.
                    if (beat) begin
                        if (bus.req_last[grant_id] || beat_cnt == BEAT_LAST) begin
                            beat_cnt <= '0;
                            state    <= ARB_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef SYNC_FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];

    // NOTE: the counter array is plain flops, not RAM, so it is cleared explicitly by both resets.
    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else if (sw_rst) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else if (state == ARB_IDLE && pick_found && cnt_q[pick_id] != '1) begin
            cnt_q[pick_id] <= cnt_q[pick_id] + 1'b1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Directed bench for sync_fifo_wr_arb: table of per-cycle vectors plus hand-written corner sequences.
module tb_sync_fifo_wr_arb;
    import sync_fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 8;

    logic       clk = 1'b0;
    logic       hw_rst;
    logic       sw_rst;
    logic [1:0] grant_id;
    logic       arb_busy;
    logic       ovf_err;
`ifdef SYNC_FIFO_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    sync_fifo_wr_arb_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    sync_fifo_wr_arb #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
`ifdef SYNC_FIFO_ARB_STATS_EN
        ,
        .CNT_W     (16)
`endif
    ) dut (
        .clk       (clk),
        .hw_rst    (hw_rst),
        .sw_rst    (sw_rst),
        .bus       (bus),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy),
        .ovf_err   (ovf_err)
`ifdef SYNC_FIFO_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [7:0]  d;
        logic [3:0]  e_ready;
        logic        e_wr;
        logic [31:0] e_data;
        logic        e_busy;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last, input logic full,
                                input logic [7:0] d, input logic [3:0] e_ready, input logic e_wr,
                                input logic [31:0] e_data, input logic e_busy, input logic [1:0] e_gid);
        vec_t v;
        v.valid = valid; v.last = last; v.full = full; v.d = d;
        v.e_ready = e_ready; v.e_wr = e_wr; v.e_data = e_data; v.e_busy = e_busy; v.e_gid = e_gid;
        return v;
    endfunction

    // Producer i always presents {A5A5, i, d}.
    task automatic set_data(input logic [7:0] d);
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = {16'hA5A5, 8'(i), d};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    initial begin
        int  sent;
        int  k;
        logic exp_wr;

        hw_rst = 1'b1;
        sw_rst = 1'b0;
        bus.req_valid     = '0;
        bus.req_last      = '0;
        bus.enq_fifo_full = 1'b0;
        bus.overflow      = 1'b0;
        set_data(8'h00);

        // Round-robin with single-beat bursts, then backpressure / valid-low / full+last on req 0.
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b0000, 0, 32'h0,          0, 2'd0));
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b0001, 1, 32'hA5A5_0000, 1, 2'd0));
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b0000, 0, 32'h0,          0, 2'd0));
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b0010, 1, 32'hA5A5_0100, 1, 2'd1));
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b0000, 0, 32'h0,          0, 2'd1));
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b0100, 1, 32'hA5A5_0200, 1, 2'd2));
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b0000, 0, 32'h0,          0, 2'd2));
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b1000, 1, 32'hA5A5_0300, 1, 2'd3));
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b0000, 0, 32'h0,          0, 2'd3));
        vq.push_back(mk(4'b1111, 4'b1111, 0, 8'h00, 4'b0001, 1, 32'hA5A5_0000, 1, 2'd0));
        vq.push_back(mk(4'b0001, 4'b0000, 0, 8'h00, 4'b0000, 0, 32'h0,          0, 2'd0));
        vq.push_back(mk(4'b0001, 4'b0000, 0, 8'h01, 4'b0001, 1, 32'hA5A5_0001, 1, 2'd0));
        vq.push_back(mk(4'b0001, 4'b0000, 0, 8'h02, 4'b0001, 1, 32'hA5A5_0002, 1, 2'd0));
        vq.push_back(mk(4'b0000, 4'b0000, 0, 8'h02, 4'b0001, 0, 32'h0,          1, 2'd0));
        vq.push_back(mk(4'b0001, 4'b0000, 1, 8'h03, 4'b0000, 0, 32'h0,          1, 2'd0));
        vq.push_back(mk(4'b0001, 4'b0000, 1, 8'h03, 4'b0000, 0, 32'h0,          1, 2'd0));
        vq.push_back(mk(4'b0001, 4'b0001, 1, 8'h03, 4'b0000, 0, 32'h0,          1, 2'd0));
        vq.push_back(mk(4'b0001, 4'b0000, 0, 8'h03, 4'b0001, 1, 32'hA5A5_0003, 1, 2'd0));
        vq.push_back(mk(4'b0001, 4'b0001, 0, 8'h04, 4'b0001, 1, 32'hA5A5_0004, 1, 2'd0));
        vq.push_back(mk(4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 0, 32'h0,          0, 2'd0));

        #2;
        check("rst ready",   32'(bus.req_ready), 32'h0);
        check("rst wr_en",   32'(bus.top_wr_en), 32'h0);
        check("rst wr_data", bus.top_wr_data,    32'h0);
        check("rst busy",    32'(arb_busy),      32'h0);
        check("rst gid",     32'(grant_id),      32'h0);
        check("rst ovf",     32'(ovf_err),       32'h0);
        repeat (2) @(posedge clk);
        #3 hw_rst = 1'b0;
        next_cycle();

        foreach (vq[i]) begin
            bus.req_valid     = vq[i].valid;
            bus.req_last      = vq[i].last;
            bus.enq_fifo_full = vq[i].full;
            set_data(vq[i].d);
            mid();
            check($sformatf("vec%0d ready", i), 32'(bus.req_ready), 32'(vq[i].e_ready));
            check($sformatf("vec%0d wr_en", i), 32'(bus.top_wr_en), 32'(vq[i].e_wr));
            check($sformatf("vec%0d data", i),  bus.top_wr_data,    vq[i].e_data);
            check($sformatf("vec%0d busy", i),  32'(arb_busy),      32'(vq[i].e_busy));
            check($sformatf("vec%0d gid", i),   32'(grant_id),      32'(vq[i].e_gid));
            next_cycle();
        end

        // Burst limit: req 1 streams 20 beats without last -> 8, bubble, 8, bubble, 4.
        sent = 0;
        k    = 0;
        bus.req_last = '0;
        for (int c = 0; c < 26; c++) begin
            bus.req_valid = (sent < 20) ? 4'b0010 : 4'b0000;
            set_data(8'(sent));
            mid();
            exp_wr = (c >= 1 && c <= 8) || (c >= 10 && c <= 17) || (c >= 19 && c <= 22);
            check($sformatf("burst c%0d wr_en", c), 32'(bus.top_wr_en), 32'(exp_wr));
            if (exp_wr) begin
                check($sformatf("burst c%0d data", c), bus.top_wr_data, {16'hA5A5, 8'h01, 8'(k)});
                k++;
            end
            if (bus.req_valid[1] && bus.req_ready[1]) sent++;
            next_cycle();
        end
        check("burst beats", 32'(sent), 32'd20);
        mid();
        check("burst held busy", 32'(arb_busy), 32'h1);
        check("burst held gid",  32'(grant_id), 32'h1);

        // Asynchronous hw_rst asserted mid-cycle while req 1 is writing.
        next_cycle();
        bus.req_valid = 4'b0010;
        set_data(8'h14);
        #1;
        check("pre-rst wr_en", 32'(bus.top_wr_en), 32'h1);
        hw_rst = 1'b1;
        #1;
        check("async rst ready", 32'(bus.req_ready), 32'h0);
        check("async rst wr_en", 32'(bus.top_wr_en), 32'h0);
        check("async rst data",  bus.top_wr_data,    32'h0);
        check("async rst busy",  32'(arb_busy),      32'h0);
        check("async rst gid",   32'(grant_id),      32'h0);
        #2;
        hw_rst = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b0000;
        set_data(8'h00);
        next_cycle();
        mid();
        check("post-rst gid",   32'(grant_id),      32'h0);
        check("post-rst busy",  32'(arb_busy),      32'h1);
        check("post-rst ready", 32'(bus.req_ready), 32'h1);

        // sw_rst on beat 2 of a burst from req 2.
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0001;
        #1;
        check("swr close wr_en", 32'(bus.top_wr_en), 32'h1);
        next_cycle();
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b0000;
        mid();
        check("swr idle busy", 32'(arb_busy), 32'h0);
        next_cycle();
        set_data(8'h01);
        mid();
        check("swr beat1 wr_en", 32'(bus.top_wr_en), 32'h1);
        check("swr beat1 data",  bus.top_wr_data,    32'hA5A5_0201);
        check("swr beat1 gid",   32'(grant_id),      32'h2);
        next_cycle();
        sw_rst = 1'b1;
        set_data(8'h02);
        mid();
        check("swr beat2 wr_en", 32'(bus.top_wr_en), 32'h0);
        check("swr beat2 ready", 32'(bus.req_ready), 32'h0);
        check("swr beat2 data",  bus.top_wr_data,    32'h0);
        next_cycle();
        sw_rst = 1'b0;
        bus.req_valid = 4'b0101;
        mid();
        check("swr after busy",  32'(arb_busy),      32'h0);
        check("swr after ready", 32'(bus.req_ready), 32'h0);
        next_cycle();
        mid();
        check("swr regrant gid",   32'(grant_id),      32'h0);
        check("swr regrant busy",  32'(arb_busy),      32'h1);
        check("swr regrant ready", 32'(bus.req_ready), 32'h1);

        // Five single-beat bursts from req 0, then sticky overflow error.
        next_cycle();
        sw_rst = 1'b1;
        bus.req_valid = 4'b0000;
        next_cycle();
        sw_rst = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus.req_valid = 4'b0001;
            bus.req_last  = 4'b0001;
            set_data(8'(b));
            mid();
            check($sformatf("single%0d idle busy", b), 32'(arb_busy), 32'h0);
            next_cycle();
            mid();
            check($sformatf("single%0d wr_en", b), 32'(bus.top_wr_en), 32'h1);
            check($sformatf("single%0d data", b),  bus.top_wr_data,    {16'hA5A5, 8'h00, 8'(b)});
            next_cycle();
        end
        bus.req_valid = 4'b0000;
        mid();
`ifdef SYNC_FIFO_ARB_STATS_EN
        check("grant_cnt0", 32'(grant_cnt[15:0]),  32'd5);
        check("grant_cnt1", 32'(grant_cnt[31:16]), 32'd0);
`endif
        check("ovf before", 32'(ovf_err), 32'h0);
        next_cycle();
        bus.overflow = 1'b1;
        next_cycle();
        bus.overflow = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mid();
            check($sformatf("ovf sticky%0d", c), 32'(ovf_err), 32'h1);
            next_cycle();
        end
        sw_rst = 1'b1;
        next_cycle();
        sw_rst = 1'b0;
        mid();
        check("ovf cleared", 32'(ovf_err), 32'h0);
`ifdef SYNC_FIFO_ARB_STATS_EN
        check("grant_cnt cleared", 32'(grant_cnt[15:0]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
